// File: rtl/custom_axi_ip_lite_regs.sv
`timescale 1ns/1ps
// custom_axi_ip_lite_regs
// AXI4-Lite slave register block in front of the custom IP core.
// Map: 0x00 CTRL, 0x04 DATA_IN, 0x08 DATA_OUT, 0x0C STATUS, 0x10 IRQ_MASK.
// Optional feature: define CUSTOM_AXI_IP_IRQ_EN to add IRQ_MASK and irq_o.
module custom_axi_ip_lite_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                    enable_o,
  input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
  input  logic [1:0]              status_i
`ifdef CUSTOM_AXI_IP_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_DIN     = 3'd1;
  localparam logic [2:0] IDX_DOUT    = 3'd2;
  localparam logic [2:0] IDX_STAT    = 3'd3;
`ifdef CUSTOM_AXI_IP_IRQ_EN
  localparam logic [2:0] IDX_IRQM    = 3'd4;
`endif

  // Word index (address bits [4:2]) that decodes to a real register.
  function automatic logic is_mapped(input logic [2:0] idx);
`ifdef CUSTOM_AXI_IP_IRQ_EN
    return idx <= IDX_IRQM;
`else
    return idx <= IDX_STAT;
`endif
  endfunction

  logic                  aw_held;
  logic                  w_held;
  logic [2:0]            aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [1:0]            status_q;
  logic                  done_stky;
  logic                  start_err;
`ifdef CUSTOM_AXI_IP_IRQ_EN
  logic                  irq_mask_q;
`endif

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  commit;
  logic                  start_req;
  logic                  start_ok;
  logic                  w1c_en;
  logic                  din_we;
  logic [2:0]            ar_idx;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_word;

  // Address bits outside [4:2] are intentionally ignored (registers alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[ADDR_WIDTH-1:5], s_awaddr[1:0],
                              s_araddr[ADDR_WIDTH-1:5], s_araddr[1:0]};

  // Ready is forced low while reset is asserted so no channel looks live.
  assign s_awready = ~rst_i & ~aw_held & ~s_bvalid;
  assign s_wready  = ~rst_i & ~w_held  & ~s_bvalid;
  assign s_arready = ~rst_i & ~s_rvalid;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;

  // A write commits on the first edge at which both address and data are held.
  assign commit    = aw_held & w_held & ~s_bvalid;
  assign start_req = commit & (aw_idx_q == IDX_CTRL) & w_strb_q[0] & w_data_q[0];
  assign start_ok  = start_req & (status_q == ST_IDLE);
  assign w1c_en    = commit & (aw_idx_q == IDX_STAT) & w_strb_q[1];
  assign din_we    = commit & (aw_idx_q == IDX_DIN);

  assign ar_idx       = s_araddr[4:2];
  assign ipreg_data_o = data_in_q;
  assign status_word  = {{(DATA_WIDTH-10){1'b0}}, start_err, done_stky, 6'b0, status_q};

  // Read mux over the register state as it stands before the AR edge.
  always_comb begin
    rd_word = '0;
    case (ar_idx)
      IDX_DIN:  rd_word = data_in_q;
      IDX_DOUT: rd_word = data_out_q;
      IDX_STAT: rd_word = status_word;
`ifdef CUSTOM_AXI_IP_IRQ_EN
      IDX_IRQM: rd_word = {{(DATA_WIDTH-1){1'b0}}, irq_mask_q};
`endif
      default:  rd_word = '0;
    endcase
  end

  // Write holding flags and the B channel; buffers free up on the B handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (b_hs) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      s_bvalid <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Captured write payload; only consumed while the held flags are set.
  always_ff @(posedge clk_i) begin
    if (aw_hs) aw_idx_q <= s_awaddr[4:2];
    if (w_hs) begin
      w_data_q <= s_wdata;
      w_strb_q <= s_wstrb;
    end
  end

  // R channel: capture on AR handshake, hold until R handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_rvalid <= 1'b0;
      s_rresp  <= RESP_OKAY;
      s_rdata  <= '0;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_word;
      s_rresp  <= is_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      s_rvalid <= 1'b0;
    end
  end

  // DATA_IN: byte-strobed update at the commit edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_in_q <= '0;
    end else if (din_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) data_in_q[8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  // DATA_OUT tracks the core result word every cycle.
  always_ff @(posedge clk_i) begin
    data_out_q <= ipreg_data_i;
  end

  // Core state sample, sticky flags (set beats clear) and the start pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q  <= ST_IDLE;
      done_stky <= 1'b0;
      start_err <= 1'b0;
      enable_o  <= 1'b0;
    end else begin
      status_q <= status_i;
      enable_o <= start_ok;
      if (status_q == ST_DONE)         done_stky <= 1'b1;
      else if (w1c_en && w_data_q[8])  done_stky <= 1'b0;
      if (start_req && !start_ok)      start_err <= 1'b1;
      else if (w1c_en && w_data_q[9])  start_err <= 1'b0;
    end
  end

`ifdef CUSTOM_AXI_IP_IRQ_EN
  // Interrupt mask register and registered interrupt output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_mask_q <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      if (commit && (aw_idx_q == IDX_IRQM) && w_strb_q[0]) irq_mask_q <= w_data_q[0];
      irq_o <= done_stky & irq_mask_q;
    end
  end
`endif

endmodule

// File: tb/tb_custom_axi_ip_lite_regs.sv
`timescale 1ns/1ps
// tb_custom_axi_ip_lite_regs
// Directed vector table, hand-written corner sequences and a randomized
// phase checked against a transaction-level register model.
module tb_custom_axi_ip_lite_regs;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [7:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] ipreg_data_o;
  logic        enable_o;
  logic [31:0] ipreg_data_i;
  logic [1:0]  status_i;
`ifdef CUSTOM_AXI_IP_IRQ_EN
  logic        irq_o;
`endif

  always #5 clk_i = ~clk_i;

  custom_axi_ip_lite_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
    .ipreg_data_i(ipreg_data_i), .status_i(status_i)
`ifdef CUSTOM_AXI_IP_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_pulses = 0;

  // Count every cycle enable_o is high.
  always @(negedge clk_i) if (enable_o === 1'b1) en_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // order: 0 = AW before W, 1 = W before AW, 2 = same cycle.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int hold_b,
                           output logic [1:0] resp, output logic en_at_commit);
    bit a, b, aw_done, w_done;
    int t;
    resp = 2'bxx;
    en_at_commit = 1'bx;
    aw_done = 0;
    w_done  = 0;
    @(negedge clk_i);
    if (order != 1) begin s_awaddr = addr; s_awvalid = 1'b1; end
    if (order != 0) begin s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; end
    t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      a = s_awvalid && s_awready;
      b = s_wvalid && s_wready;
      @(posedge clk_i);
      @(negedge clk_i);
      if (a) begin
        aw_done = 1; s_awvalid = 1'b0;
        if (order == 0) begin s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; end
      end
      if (b) begin
        w_done = 1; s_wvalid = 1'b0;
        if (order == 1) begin s_awaddr = addr; s_awvalid = 1'b1; end
      end
      t++;
    end
    if (!(aw_done && w_done)) begin
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      timeout_fail("write addr/data");
      return;
    end
    t = 0;
    while (!s_bvalid && t < 20) begin @(negedge clk_i); t++; end
    if (!s_bvalid) begin timeout_fail("write bvalid"); return; end
    resp = s_bresp;
    en_at_commit = enable_o;
    for (int i = 0; i < hold_b; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold awready", 32'(s_awready), 32'd0);
      check("hold bvalid", 32'(s_bvalid), 32'd1);
    end
    s_bready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit a;
    int t;
    data = 32'hxxxx_xxxx;
    resp = 2'bxx;
    @(negedge clk_i);
    s_araddr = addr; s_arvalid = 1'b1;
    t = 0;
    a = 0;
    while (!a && t < 50) begin
      a = s_arready;
      @(posedge clk_i);
      @(negedge clk_i);
      t++;
    end
    s_arvalid = 1'b0;
    if (!s_rvalid) begin timeout_fail("read rvalid"); return; end
    data = s_rdata;
    resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    s_rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " awready"}, 32'(s_awready), 32'd0);
    check({tag, " wready"},  32'(s_wready),  32'd0);
    check({tag, " arready"}, 32'(s_arready), 32'd0);
    check({tag, " bvalid"},  32'(s_bvalid),  32'd0);
    check({tag, " rvalid"},  32'(s_rvalid),  32'd0);
    check({tag, " rdata"},   s_rdata,        32'd0);
    check({tag, " resp"},    32'({s_bresp, s_rresp}), 32'd0);
    check({tag, " ipreg_data_o"}, ipreg_data_o, 32'd0);
    check({tag, " enable_o"}, 32'(enable_o), 32'd0);
`ifdef CUSTOM_AXI_IP_IRQ_EN
    check({tag, " irq_o"}, 32'(irq_o), 32'd0);
`endif
  endtask

  // Transaction-level model of the register file.
  logic [31:0] m_data_in, m_dout;
  logic        m_done, m_err, m_mask;
  logic [1:0]  m_status;
  int          m_pulses;

  task automatic model_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output logic pulse);
    r = 2'b00;
    pulse = 1'b0;
    case (off)
      3'd0: if (s[0] && d[0]) begin
              if (m_status == 2'd0) begin pulse = 1'b1; m_pulses++; end
              else m_err = 1'b1;
            end
      3'd1: for (int i = 0; i < 4; i++) if (s[i]) m_data_in[8*i +: 8] = d[8*i +: 8];
      3'd3: if (s[1]) begin
              if (d[8] && m_status != 2'd2) m_done = 1'b0;
              if (d[9]) m_err = 1'b0;
            end
      3'd4: begin
`ifdef CUSTOM_AXI_IP_IRQ_EN
              if (s[0]) m_mask = d[0];
`else
              r = 2'b10;
`endif
            end
      3'd5, 3'd6, 3'd7: r = 2'b10;
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [2:0] off, output logic [31:0] d, output logic [1:0] r);
    d = 32'd0;
    r = 2'b00;
    case (off)
      3'd1: d = m_data_in;
      3'd2: d = m_dout;
      3'd3: d = {22'd0, m_err, m_done, 6'd0, m_status};
      3'd4: begin
`ifdef CUSTOM_AXI_IP_IRQ_EN
              d = {31'd0, m_mask};
`else
              r = 2'b10;
`endif
            end
      3'd5, 3'd6, 3'd7: r = 2'b10;
      default: ;
    endcase
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          order;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [1:0]  resp, eresp;
  logic [31:0] rdata, edata;
  logic        en, epulse;
  int          p0;

  // Global watchdog.
  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h04, 32'hDEADBEEF, 4'b0101, 0, 2'b00, 32'h00AD00EF, 2'b00};
    vecs[1]  = '{8'h04, 32'h12345678, 4'b1111, 1, 2'b00, 32'h12345678, 2'b00};
    vecs[2]  = '{8'h04, 32'hAABBCCDD, 4'b0010, 2, 2'b00, 32'h1234CC78, 2'b00};
    vecs[3]  = '{8'h24, 32'h00000055, 4'b0001, 0, 2'b00, 32'h1234CC55, 2'b00};
    vecs[4]  = '{8'h08, 32'hFFFFFFFF, 4'b1111, 1, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[5]  = '{8'h0C, 32'h00000003, 4'b1111, 2, 2'b00, 32'h00000000, 2'b00};
    vecs[6]  = '{8'h14, 32'hFFFFFFFF, 4'b1111, 0, 2'b10, 32'h00000000, 2'b10};
    vecs[7]  = '{8'h18, 32'h12345678, 4'b1111, 1, 2'b10, 32'h00000000, 2'b10};
    vecs[8]  = '{8'h1C, 32'h0000FFFF, 4'b0011, 2, 2'b10, 32'h00000000, 2'b10};
`ifdef CUSTOM_AXI_IP_IRQ_EN
    vecs[9]  = '{8'h10, 32'h00000001, 4'b0001, 2, 2'b00, 32'h00000001, 2'b00};
`else
    vecs[9]  = '{8'h10, 32'h00000001, 4'b0001, 2, 2'b10, 32'h00000000, 2'b10};
`endif
    vecs[10] = '{8'h00, 32'h00000000, 4'b1111, 0, 2'b00, 32'h00000000, 2'b00};

    rst_i = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    ipreg_data_i = 32'hCAFEF00D;
    status_i = 2'd0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      p0 = en_pulses;
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].order, 0, resp, en);
      check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].bresp));
      check($sformatf("vec%0d no start", i), 32'(en_pulses - p0), 32'd0);
      axi_read(vecs[i].addr, rdata, resp);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
      check($sformatf("vec%0d rresp", i), 32'(resp), 32'(vecs[i].rresp));
      if (vecs[i].addr[4:2] == 3'd1)
        check($sformatf("vec%0d ipreg_data_o", i), ipreg_data_o, vecs[i].rdata);
    end

    // START in IDLE: exactly one enable cycle at commit, then a core job.
    p0 = en_pulses;
    axi_write(8'h00, 32'h1, 4'b0001, 2, 0, resp, en);
    check("start en at commit", 32'(en), 32'd1);
    check("start bresp", 32'(resp), 32'd0);
    @(negedge clk_i);
    check("start pulse count", 32'(en_pulses - p0), 32'd1);
    status_i = 2'd1; repeat (2) @(negedge clk_i);
    ipreg_data_i = 32'h123450F0; status_i = 2'd2; @(negedge clk_i);
    status_i = 2'd0; repeat (3) @(negedge clk_i);
    axi_read(8'h08, rdata, resp);
    check("job data_out", rdata, 32'h123450F0);
    axi_read(8'h0C, rdata, resp);
    check("job status done", rdata, 32'h00000100);
    axi_write(8'h0C, 32'h100, 4'b0010, 0, 0, resp, en);
    axi_read(8'h0C, rdata, resp);
    check("w1c done", rdata, 32'h00000000);

    // START with strobe byte 0 off: ignored.
    p0 = en_pulses;
    axi_write(8'h00, 32'hFFFFFFFF, 4'b1110, 1, 0, resp, en);
    check("start no strb", 32'(en_pulses - p0), 32'd0);

    // START while BUSY: no pulse, START_ERR set.
    status_i = 2'd1; repeat (3) @(negedge clk_i);
    p0 = en_pulses;
    axi_write(8'h00, 32'h1, 4'b0001, 0, 0, resp, en);
    check("busy start en", 32'(en), 32'd0);
    @(negedge clk_i);
    check("busy pulse count", 32'(en_pulses - p0), 32'd0);
    axi_read(8'h0C, rdata, resp);
    check("busy status", rdata, 32'h00000201);
    axi_write(8'h0C, 32'h200, 4'b0001, 2, 0, resp, en);
    axi_read(8'h0C, rdata, resp);
    check("w1c no strb", rdata, 32'h00000201);
    axi_write(8'h0C, 32'h200, 4'b0010, 2, 0, resp, en);
    axi_read(8'h0C, rdata, resp);
    check("w1c err", rdata, 32'h00000001);

    // Set beats a simultaneous W1C while status stays DONE.
    status_i = 2'd2; repeat (3) @(negedge clk_i);
    axi_write(8'h0C, 32'h100, 4'b0010, 1, 0, resp, en);
    axi_read(8'h0C, rdata, resp);
    check("set wins", rdata, 32'h00000102);
    status_i = 2'd0; repeat (3) @(negedge clk_i);
    axi_write(8'h0C, 32'h100, 4'b0010, 1, 0, resp, en);
    axi_read(8'h0C, rdata, resp);
    check("w1c after done", rdata, 32'h00000000);

    // Unmapped write with B held off for 5 cycles.
    axi_write(8'h18, 32'hFFFFFFFF, 4'b1111, 2, 5, resp, en);
    check("unmapped held bresp", 32'(resp), 32'd2);
    axi_read(8'h14, rdata, resp);
    check("unmapped rdata", rdata, 32'd0);
    check("unmapped rresp", 32'(resp), 32'd2);

`ifdef CUSTOM_AXI_IP_IRQ_EN
    // IRQ rises one cycle after DONE_STKY and falls after its W1C.
    axi_write(8'h10, 32'h1, 4'b0001, 2, 0, resp, en);
    @(negedge clk_i);
    status_i = 2'd2;
    @(negedge clk_i); check("irq E1", 32'(irq_o), 32'd0);
    @(negedge clk_i); check("irq E2", 32'(irq_o), 32'd0);
    @(negedge clk_i); check("irq E3", 32'(irq_o), 32'd1);
    status_i = 2'd0; repeat (3) @(negedge clk_i);
    check("irq held", 32'(irq_o), 32'd1);
    axi_write(8'h0C, 32'h100, 4'b0010, 2, 0, resp, en);
    check("irq after w1c", 32'(irq_o), 32'd0);
`endif

    // Asynchronous reset in the middle of a read.
    axi_write(8'h04, 32'h5A5A5A5A, 4'b1111, 2, 0, resp, en);
    @(negedge clk_i);
    s_araddr = 8'h04; s_arvalid = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    s_arvalid = 1'b0;
    check("pre-reset rvalid", 32'(s_rvalid), 32'd1);
    check("pre-reset rdata", s_rdata, 32'h5A5A5A5A);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("async reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    axi_read(8'h04, rdata, resp);
    check("data_in after reset", rdata, 32'd0);

    // Randomized phase against the model: IDLE, BUSY, DONE, IDLE.
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    m_data_in = 0; m_done = 0; m_err = 0; m_mask = 0; m_status = 0; m_pulses = 0;
    p0 = en_pulses;
    for (int ph = 0; ph < 4; ph++) begin
      status_i = (ph == 3) ? 2'd0 : 2'(ph);
      repeat (3) @(negedge clk_i);
      m_status = status_i;
      if (m_status == 2'd2) m_done = 1'b1;
      for (int k = 0; k < 30; k++) begin
        logic [2:0]  off;
        logic [7:0]  addr;
        logic [31:0] d;
        logic [3:0]  s;
        ipreg_data_i = $urandom;
        @(negedge clk_i);
        m_dout = ipreg_data_i;
        off  = 3'($urandom_range(0, 7));
        addr = {3'($urandom_range(0, 7)), off, 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          s = 4'($urandom);
          if (off == 3'd0) d[0] = ($urandom_range(0, 3) != 0);
          model_write(off, d, s, eresp, epulse);
          axi_write(addr, d, s, $urandom_range(0, 2), 0, resp, en);
          check($sformatf("rnd bresp @%02h", addr), 32'(resp), 32'(eresp));
          check($sformatf("rnd pulse @%02h", addr), 32'(en), 32'(epulse));
          check("rnd ipreg_data_o", ipreg_data_o, m_data_in);
        end else begin
          model_read(off, edata, eresp);
          axi_read(addr, rdata, resp);
          check($sformatf("rnd rdata @%02h", addr), rdata, edata);
          check($sformatf("rnd rresp @%02h", addr), 32'(resp), 32'(eresp));
        end
      end
    end
    @(negedge clk_i);
    check("rnd total pulses", 32'(en_pulses - p0), 32'(m_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/custom_axi_ip_lite_regs.md
# custom_axi_ip_lite_regs

AXI4-Lite slave register block sitting directly upstream of the custom IP core. Converts bus writes into the core's data word and single-cycle start pulse, and exposes the core's result word and state on bus reads. Adds sticky completion and protocol-error flags, plus an optional interrupt.

## Interface
Parameters:
- ADDR_WIDTH, 8, AXI address width; only bits [4:2] are decoded.
- DATA_WIDTH, 32, AXI data width; fixed at 32.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response.
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data.
- ipreg_data_o  out  32  data word to core (DATA_IN register).
- enable_o  out  1  one-cycle start pulse to core.
- ipreg_data_i  in  32  core result word.
- status_i  in  2  core state, custom_axi_ip_pkg::status_e (IDLE=0, BUSY=1, DONE=2, ERROR=3).
- irq_o  out  1  interrupt; present only with the configuration macro.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START, write-1 pulses enable_o; reads 0.
  - 0x04 DATA_IN: RW, byte-strobed via s_wstrb; drives ipreg_data_o.
  - 0x08 DATA_OUT: RO, registered copy of ipreg_data_i, updated every cycle.
  - 0x0C STATUS: [1:0] registered status_i (RO); bit8 DONE_STKY (W1C); bit9 START_ERR (W1C).
  - 0x10 IRQ_MASK: bit0 RW (macro builds only).
- START honoured only when registered status is IDLE; otherwise no pulse, START_ERR set.
- DONE_STKY sets on any cycle registered status == DONE. Set wins over simultaneous W1C.
- Writes to RO fields ignored, response OKAY (2'b00). Unmapped offsets: write ignored, read data 0, response SLVERR (2'b10).
- START/W1C bits act only when s_wstrb[0]/[1] respectively set.
- One outstanding write and one outstanding read. Channels are independent.

## Timing
- Reset values: all ready/valid outputs 0, s_bresp/s_rresp 0, s_rdata 0, ipreg_data_o 0, enable_o 0, irq_o 0, all sticky bits and IRQ_MASK 0.
- s_awready = 1 when no address held and s_bvalid = 0. s_wready behaves the same way for data.
- AW and W may complete in either order or the same cycle. Commit edge = edge after both are held.
- At the commit edge: register update, s_bvalid = 1, and enable_o = 1 for exactly that one cycle (if START is accepted).
- s_bvalid holds until s_bready. Holding buffers clear on the B handshake.
- s_arready = 1 when s_rvalid = 0. On AR handshake at edge E, s_rdata/s_rresp/s_rvalid are valid from E onward and hold until s_rready.
- Read data reflects register state at edge E. A write committing at E is not visible.
- Back-to-back START requires the core to return to IDLE. Minimum core cycle is 4 clocks.
- rst_i mid-transaction: all channels drop to reset values immediately. In-flight transactions are discarded.

## Configuration
- CUSTOM_AXI_IP_IRQ_EN defined:
  - IRQ_MASK register exists.
  - irq_o = DONE_STKY & IRQ_MASK[0], registered (one cycle after the sticky bit sets).
- Undefined:
  - 0x10 is unmapped (SLVERR).
  - irq_o port is absent.

## Test plan
- Reset: assert rst_i asynchronously mid-read → all outputs 0 within the same cycle; DATA_IN reads 0 after release.
- Write 0xDEADBEEF to 0x04 with wstrb=4'b0101, AW one cycle before W → readback 0x00AD00EF, bresp 0, ipreg_data_o matches.
- Write CTRL=1 in IDLE → enable_o high exactly one cycle at commit. Core result 0x..F0 arrives → DATA_OUT reads it, STATUS bit8=1. W1C 0x100 clears bit8.
- Write CTRL=1 while status_i=BUSY → no enable_o, STATUS reads 0x201.
- Read 0x14 and write 0x18 → rresp/bresp 2'b10, rdata 0. Hold s_bready=0 for 5 cycles → s_awready stays 0, bvalid stays 1.
- With CUSTOM_AXI_IP_IRQ_EN: IRQ_MASK=1, run a job → irq_o rises one cycle after DONE_STKY and falls after the W1C. Without the macro, read 0x10 → SLVERR.
